pc_counter: RTL and testbench
=============================

# pc_counter

Free-running program-counter register for the project CPU. It holds the address of the current instruction and advances by a fixed step on every rising clock edge. A synchronous reset returns it to its start address. The output drives the instruction-memory address bus directly.

## Interface

Parameters:
- `WIDTH`, default 8: counter and output width in bits.
- `STEP`, default 1: increment applied each cycle when not in reset (unsigned, taken modulo 2^WIDTH).
- `RESET_VALUE`, default 0: value loaded on reset (unsigned, taken modulo 2^WIDTH).

Ports (positional order is fixed as clk, rst, out):
- `clk`  input  1  system clock. Only the rising edge is active.
- `rst`  input  1  one clock; reset is synchronous and active-high. Sampled on the rising edge of `clk`.
- `out`  output  WIDTH  current PC value, driven directly from the internal register.

## Operation

- There is one WIDTH-bit register `pc`, and `out` = `pc`. `out` has no combinational path from `rst` or `clk`.
- On the rising edge of `clk`, if `rst` = 1, then `pc` <= `RESET_VALUE`.
- On the rising edge of `clk`, if `rst` = 0, then `pc` <= (`pc` + `STEP`) mod 2^WIDTH.
- Arithmetic is unsigned, and any carry out of bit WIDTH-1 is discarded. With default parameters, 8'hFF becomes 8'h00 on the next cycle, with no flag and no stall.
- Reset takes priority over counting. If reset is asserted in the middle of a count, the next edge loads `RESET_VALUE` whatever the current value.
- Reset held for N edges keeps `out` at `RESET_VALUE` for all of those edges. Counting resumes on the first edge where `rst` = 0.
- Before the first clocked reset, `pc` has no defined value (X in simulation). Users must apply reset for at least one rising edge before relying on `out`.
- The block has no enable, load or branch input. Jump and branch logic sits outside this block.

## Timing

- Latency is one cycle. A value computed at edge k is visible on `out` right after edge k and is stable until edge k+1.
- Reset has one edge of latency. `rst` must be high at a rising edge, and `out` = `RESET_VALUE` after that edge.
- Reset release: if `rst` is high at edge k and low at edge k+1, then `out` = `RESET_VALUE` after edge k and `RESET_VALUE` + `STEP` after edge k+1.
- Changes on `rst` between edges have no effect on `out`, because reset is fully synchronous.
- `out` changes only on rising edges of `clk`. A falling edge never changes `out`.
- Throughput is one increment per clock. There is no handshake.

## Test plan

- Reset then count (defaults): edge 1 with `rst`=1 gives `out`=0. Edges 2 and 3 with `rst`=0 give `out`=1, then 2. Falling edges leave `out` unchanged.
- Held reset: `rst`=1 for 4 edges keeps `out`=0 on every edge. After release, the next 3 edges give 1, 2, 3.
- Wrap-around (defaults): reset, then 255 edges with `rst`=0 give `out`=255. One more edge gives 0, and the next gives 1.
- Mid-count reset: count to 0x37, then assert `rst` for one edge. `out` becomes 0, and the next edge gives 1.
- Asynchronous glitch rejection: pulse `rst` high between two rising edges and return it low before the next edge. `out` keeps incrementing normally, with no reset.
- Parameter variant: WIDTH=4, STEP=3, RESET_VALUE=2. After reset `out`=2, then the sequence is 5, 8, 11, 14, 1 (wraps mod 16).

Source files
------------

// File: rtl/pc_counter.sv
// Program-counter register: advances by STEP every rising edge, and a synchronous
// reset loads RESET_VALUE. The output comes straight from the register.
module pc_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  // Truncate the constants once so the carry out of the MSB drops naturally.
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q + STEP_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_W;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out = pc_q;

endmodule

// File: tb/tb_pc_counter.sv
// Bench for pc_counter: a default instance and a WIDTH=4/STEP=3/RESET_VALUE=2 instance
// share clk/rst and are checked against a closed-form "edges since reset" model.
module tb_pc_counter;

  logic       clk;
  logic       rst;
  logic [7:0] out_d;
  logic [3:0] out_v;

  int unsigned checks;
  int unsigned errors;

  longint unsigned since;
  bit              valid;

  pc_counter dut_def (
    .clk (clk),
    .rst (rst),
    .out (out_d)
  );

  pc_counter #(
    .WIDTH       (4),
    .STEP        (3),
    .RESET_VALUE (2)
  ) dut_var (
    .clk (clk),
    .rst (rst),
    .out (out_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value after k counting edges following the last reset edge.
  function automatic logic [31:0] model(int unsigned w, longint unsigned rv,
                                        longint unsigned st, longint unsigned k);
    longint unsigned m;
    m = 64'd1 << w;
    return 32'((rv + st * k) % m);
  endfunction

  // Drive rst, take one rising edge, compare both instances, then confirm the
  // falling edge left the outputs untouched.
  task automatic tick(input logic r);
    logic [7:0] hold_d;
    logic [3:0] hold_v;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      since = 0;
      valid = 1'b1;
    end else begin
      since++;
    end
    if (valid) begin
      check("out_def", 32'(out_d), model(8, 0, 1, since));
      check("out_var", 32'(out_v), model(4, 2, 3, since));
    end
    hold_d = out_d;
    hold_v = out_v;
    @(negedge clk);
    #1;
    if (valid) begin
      check("negedge_def", 32'(out_d), 32'(hold_d));
      check("negedge_var", 32'(out_v), 32'(hold_v));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    since  = 0;
    valid  = 1'b0;
    rst    = 1'b1;
    @(negedge clk);

    // Reset then count; variant walks 2,5,8,11,14,1.
    tick(1'b1);
    check("rst_def", 32'(out_d), 32'd0);
    check("rst_var", 32'(out_v), 32'd2);
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("var_wrap", 32'(out_v), 32'd1);

    // Held reset for four edges, then release.
    for (int i = 0; i < 4; i++) tick(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0);
    check("held_release", 32'(out_d), 32'd3);

    // Wrap-around of the default instance.
    tick(1'b1);
    for (int i = 0; i < 255; i++) tick(1'b0);
    check("wrap_ff", 32'(out_d), 32'hff);
    tick(1'b0);
    check("wrap_00", 32'(out_d), 32'h00);
    tick(1'b0);
    check("wrap_01", 32'(out_d), 32'h01);

    // Mid-count reset.
    tick(1'b1);
    for (int i = 0; i < 'h37; i++) tick(1'b0);
    check("mid_37", 32'(out_d), 32'h37);
    tick(1'b1);
    check("mid_rst", 32'(out_d), 32'h00);
    tick(1'b0);
    check("mid_after", 32'(out_d), 32'h01);

    // Reset pulse strictly between rising edges must be ignored.
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      tick(1'b0);
    end

    // Randomized reset pattern.
    for (int i = 0; i < 400; i++) tick($urandom_range(0, 11) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
